// File: rtl/pulse_train_analyzer_if.sv
// Control and measurement bundle for the pulse train analyzer.
// The master side drives the train and settings; the analyzer is the slave.
interface pulse_train_analyzer_if #(
    parameter int CNT_W = 32
);
    logic             enable;
    logic             pulse_in;
    logic [CNT_W-1:0] timeout_cycles;
    logic [CNT_W-1:0] pw_meas;
    logic [CNT_W-1:0] pri_meas;
    logic             meas_valid;
    logic             meas_sat;
    logic [CNT_W-1:0] pulse_count;
    logic             no_signal;

    modport master (
        output enable,
        output pulse_in,
        output timeout_cycles,
        input  pw_meas,
        input  pri_meas,
        input  meas_valid,
        input  meas_sat,
        input  pulse_count,
        input  no_signal
    );

    modport slave (
        input  enable,
        input  pulse_in,
        input  timeout_cycles,
        output pw_meas,
        output pri_meas,
        output meas_valid,
        output meas_sat,
        output pulse_count,
        output no_signal
    );
endinterface

// File: rtl/pulse_train_analyzer.sv
// Measures pulse width, repetition interval and count of an async pulse train,
// with loss-of-signal timeout, in clk_in cycles.
module pulse_train_analyzer #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input logic                   clk_in,
    input logic                   reset,
    pulse_train_analyzer_if.slave bus
);

    typedef enum logic [1:0] {
        S_ARM,
        S_WAIT,
        S_HIGH,
        S_LOW
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]       FILL_DONE = 2'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   pulse_d_q, pulse_d_d;
    logic [1:0]             fill_q, fill_d;
    logic                   en_q, en_d;
    state_t                 state_q, state_d;

    logic [CNT_W-1:0] pw_cnt_q, pw_cnt_d;
    logic [CNT_W-1:0] pri_cnt_q, pri_cnt_d;
    logic [CNT_W-1:0] pw_hold_q, pw_hold_d;
    logic             pw_sat_q, pw_sat_d;
    logic             pri_sat_q, pri_sat_d;
    logic             hold_sat_q, hold_sat_d;

    logic [CNT_W-1:0] pw_meas_q, pw_meas_d;
    logic [CNT_W-1:0] pri_meas_q, pri_meas_d;
    logic             meas_valid_q, meas_valid_d;
    logic             meas_sat_q, meas_sat_d;
    logic [CNT_W-1:0] pulse_count_q, pulse_count_d;
    logic             no_signal_q, no_signal_d;

    logic pulse_s;
    logic primed;
    logic rise;
    logic fall;
    logic tmo_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    assign pulse_s = sync_q[SYNC_STAGES-1];
    // the synchronizer flops reset low, so pulse_s is only trusted once
    // it reflects a real sample; this stops a line already high at reset
    // release from looking like a fresh rising edge
    assign primed  = (fill_q == FILL_DONE);
    assign rise    = pulse_s & ~pulse_d_q;
    assign fall    = ~pulse_s & pulse_d_q;
    assign tmo_hit = (bus.timeout_cycles != '0) &&
                     (pri_cnt_q >= bus.timeout_cycles);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync_q        <= '0;
            pulse_d_q     <= 1'b0;
            fill_q        <= '0;
            en_q          <= 1'b0;
            state_q       <= S_ARM;
            pw_cnt_q      <= '0;
            pri_cnt_q     <= '0;
            pw_hold_q     <= '0;
            pw_sat_q      <= 1'b0;
            pri_sat_q     <= 1'b0;
            hold_sat_q    <= 1'b0;
            pw_meas_q     <= '0;
            pri_meas_q    <= '0;
            meas_valid_q  <= 1'b0;
            meas_sat_q    <= 1'b0;
            pulse_count_q <= '0;
            no_signal_q   <= 1'b1;
        end else begin
            sync_q        <= sync_d;
            pulse_d_q     <= pulse_d_d;
            fill_q        <= fill_d;
            en_q          <= en_d;
            state_q       <= state_d;
            pw_cnt_q      <= pw_cnt_d;
            pri_cnt_q     <= pri_cnt_d;
            pw_hold_q     <= pw_hold_d;
            pw_sat_q      <= pw_sat_d;
            pri_sat_q     <= pri_sat_d;
            hold_sat_q    <= hold_sat_d;
            pw_meas_q     <= pw_meas_d;
            pri_meas_q    <= pri_meas_d;
            meas_valid_q  <= meas_valid_d;
            meas_sat_q    <= meas_sat_d;
            pulse_count_q <= pulse_count_d;
            no_signal_q   <= no_signal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!bus.enable) begin
            state_d = S_ARM;
        end else begin
            unique case (state_q)
                S_ARM: begin
                    if (primed && !pulse_s) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (rise) state_d = S_HIGH;
                end
                S_HIGH: begin
                    if (tmo_hit)   state_d = S_WAIT;
                    else if (fall) state_d = S_LOW;
                end
                S_LOW: begin
                    if (rise)         state_d = S_HIGH;
                    else if (tmo_hit) state_d = S_WAIT;
                end
                default: state_d = S_ARM;
            endcase
        end
    end

    always_comb begin
        sync_d        = {sync_q[SYNC_STAGES-2:0], bus.pulse_in};
        pulse_d_d     = pulse_s;
        fill_d        = primed ? fill_q : fill_q + 2'd1;
        en_d          = bus.enable;
        pw_cnt_d      = pw_cnt_q;
        pri_cnt_d     = pri_cnt_q;
        pw_hold_d     = pw_hold_q;
        pw_sat_d      = pw_sat_q;
        pri_sat_d     = pri_sat_q;
        hold_sat_d    = hold_sat_q;
        pw_meas_d     = pw_meas_q;
        pri_meas_d    = pri_meas_q;
        meas_valid_d  = 1'b0;
        meas_sat_d    = meas_sat_q;
        pulse_count_d = pulse_count_q;
        no_signal_d   = no_signal_q;

        if (!bus.enable) begin
            pw_cnt_d    = '0;
            pri_cnt_d   = '0;
            pw_hold_d   = '0;
            pw_sat_d    = 1'b0;
            pri_sat_d   = 1'b0;
            hold_sat_d  = 1'b0;
            no_signal_d = 1'b1;
        end else begin
            if (!en_q) pulse_count_d = '0;
            unique case (state_q)
                S_WAIT: begin
                    if (rise) begin
                        pw_cnt_d      = CNT_ONE;
                        pri_cnt_d     = CNT_ONE;
                        pw_sat_d      = 1'b0;
                        pri_sat_d     = 1'b0;
                        pulse_count_d = pulse_count_q + CNT_ONE;
                        no_signal_d   = 1'b0;
                    end
                end
                S_HIGH: begin
                    if (tmo_hit) begin
                        no_signal_d = 1'b1;
                    end else begin
                        pri_cnt_d = sat_inc(pri_cnt_q);
                        pri_sat_d = pri_sat_q | (pri_cnt_q == CNT_MAX);
                        if (pulse_s) begin
                            pw_cnt_d = sat_inc(pw_cnt_q);
                            pw_sat_d = pw_sat_q | (pw_cnt_q == CNT_MAX);
                        end
                        if (fall) begin
                            pw_hold_d  = pw_cnt_q;
                            hold_sat_d = pw_sat_q;
                        end
                    end
                end
                S_LOW: begin
                    // a rise landing on the timeout cycle still closes the period
                    if (rise) begin
                        pw_meas_d     = pw_hold_q;
                        pri_meas_d    = pri_cnt_q;
                        meas_sat_d    = hold_sat_q | pri_sat_q;
                        meas_valid_d  = 1'b1;
                        pulse_count_d = pulse_count_q + CNT_ONE;
                        pw_cnt_d      = CNT_ONE;
                        pri_cnt_d     = CNT_ONE;
                        pw_sat_d      = 1'b0;
                        pri_sat_d     = 1'b0;
                    end else if (tmo_hit) begin
                        no_signal_d = 1'b1;
                    end else begin
                        pri_cnt_d = sat_inc(pri_cnt_q);
                        pri_sat_d = pri_sat_q | (pri_cnt_q == CNT_MAX);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.pw_meas     = pw_meas_q;
    assign bus.pri_meas    = pri_meas_q;
    assign bus.meas_valid  = meas_valid_q;
    assign bus.meas_sat    = meas_sat_q;
    assign bus.pulse_count = pulse_count_q;
    assign bus.no_signal   = no_signal_q;

endmodule

// File: tb/tb_pulse_train_analyzer.sv
// Scoreboard bench for pulse_train_analyzer: a 32-bit and an 8-bit instance
// driven with directed and random pulse trains against a period-level model.
module tb_pulse_train_analyzer;

    typedef struct {
        longint unsigned pw;
        longint unsigned pri;
        bit              sat;
        longint unsigned cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pulse_train_analyzer_if #(.CNT_W(32)) bus32 ();
    pulse_train_analyzer_if #(.CNT_W(8))  bus8 ();

    pulse_train_analyzer #(.CNT_W(32), .SYNC_STAGES(2)) dut32 (
        .clk_in (clk),
        .reset  (rst),
        .bus    (bus32)
    );

    pulse_train_analyzer #(.CNT_W(8), .SYNC_STAGES(2)) dut8 (
        .clk_in (clk),
        .reset  (rst),
        .bus    (bus8)
    );

    int n_chk  = 0;
    int n_fail = 0;

    exp_t q32[$];
    exp_t q8[$];

    // period-level model state per instance (0: 32-bit, 1: 8-bit)
    bit              have_prev[2];
    longint unsigned prev_h[2];
    longint unsigned prev_p[2];
    longint unsigned cnt[2];
    longint unsigned tmo[2];
    longint unsigned last_pw[2];
    longint unsigned last_pri[2];

    logic [63:0] lpw[2];
    logic [63:0] lpri[2];
    logic        lsat[2];
    bit          pv[2];

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    function automatic longint unsigned maxv(int sel);
        return (sel == 1) ? 64'd255 : 64'hFFFF_FFFF;
    endfunction

    function automatic bit timed_out(int sel);
        return (tmo[sel] != 0) && (tmo[sel] < prev_p[sel]);
    endfunction

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_pin(int sel, bit v);
        if (sel == 1) bus8.pulse_in = v;
        else bus32.pulse_in = v;
    endtask

    task automatic set_tmo(int sel, longint unsigned v);
        tmo[sel] = v;
        if (sel == 1) bus8.timeout_cycles = 8'(v);
        else bus32.timeout_cycles = 32'(v);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            have_prev[i] = 1'b0;
            cnt[i]       = 0;
        end
    endtask

    task automatic rearm(int sel, int n);
        set_pin(sel, 1'b0);
        have_prev[sel] = 1'b0;
        step(n);
    endtask

    // one rise, h cycles high then l cycles low
    task automatic send_pulse(int sel, int h, int l);
        exp_t            e;
        longint unsigned mx;
        mx = maxv(sel);
        if (have_prev[sel]) begin
            e.pw  = (prev_h[sel] > mx) ? mx : prev_h[sel];
            e.pri = (prev_p[sel] > mx) ? mx : prev_p[sel];
            e.sat = (prev_h[sel] > mx) || (prev_p[sel] > mx);
            e.cnt = (cnt[sel] + 1) & mx;
            last_pw[sel]  = e.pw;
            last_pri[sel] = e.pri;
            if (sel == 1) q8.push_back(e);
            else q32.push_back(e);
        end
        cnt[sel]       = (cnt[sel] + 1) & mx;
        prev_h[sel]    = longint'(h);
        prev_p[sel]    = longint'(h + l);
        have_prev[sel] = !timed_out(sel);
        set_pin(sel, 1'b1);
        step(h);
        set_pin(sel, 1'b0);
        step(l);
    endtask

    task automatic idle(int sel, int n);
        prev_p[sel]    = prev_p[sel] + longint'(n);
        have_prev[sel] = have_prev[sel] && !timed_out(sel);
        step(n);
    endtask

    task automatic mon(int sel, logic v, logic [63:0] pw, logic [63:0] pri,
                       logic sat, logic [63:0] pc, logic ns);
        exp_t e;
        bit   empty;
        if (rst) begin
            pv[sel] = 1'b0;
        end else if (v) begin
            check($sformatf("b2b_valid%0d", sel), 64'(pv[sel]), 64'd0);
            empty = (sel == 1) ? (q8.size() == 0) : (q32.size() == 0);
            if (empty) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_valid%0d: got meas_valid=1 pw=%0d pri=%0d required no publish",
                         sel, pw, pri);
            end else begin
                if (sel == 1) e = q8.pop_front();
                else e = q32.pop_front();
                check($sformatf("pw_meas%0d", sel), pw, e.pw);
                check($sformatf("pri_meas%0d", sel), pri, e.pri);
                check($sformatf("meas_sat%0d", sel), 64'(sat), 64'(e.sat));
                check($sformatf("pulse_count_at_valid%0d", sel), pc, e.cnt);
                check($sformatf("no_signal_at_valid%0d", sel), 64'(ns), 64'd0);
            end
        end else begin
            check($sformatf("pw_hold%0d", sel), pw, lpw[sel]);
            check($sformatf("pri_hold%0d", sel), pri, lpri[sel]);
            check($sformatf("sat_hold%0d", sel), 64'(sat), 64'(lsat[sel]));
        end
        lpw[sel]  = pw;
        lpri[sel] = pri;
        lsat[sel] = sat;
        pv[sel]   = v;
    endtask

    always @(negedge clk) begin
        mon(0, bus32.meas_valid, 64'(bus32.pw_meas), 64'(bus32.pri_meas),
            bus32.meas_sat, 64'(bus32.pulse_count), bus32.no_signal);
        mon(1, bus8.meas_valid, 64'(bus8.pw_meas), 64'(bus8.pri_meas),
            bus8.meas_sat, 64'(bus8.pulse_count), bus8.no_signal);
    end

    task automatic check_reset_vals(string tag);
        check({tag, "_pw"}, 64'(bus32.pw_meas), 64'd0);
        check({tag, "_pri"}, 64'(bus32.pri_meas), 64'd0);
        check({tag, "_valid"}, 64'(bus32.meas_valid), 64'd0);
        check({tag, "_sat"}, 64'(bus32.meas_sat), 64'd0);
        check({tag, "_count"}, 64'(bus32.pulse_count), 64'd0);
        check({tag, "_no_signal"}, 64'(bus32.no_signal), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        bus32.enable   = 1'b1;
        bus32.pulse_in = 1'b0;
        bus8.enable    = 1'b0;
        bus8.pulse_in  = 1'b0;
        set_tmo(0, 50);
        set_tmo(1, 0);
        model_reset();
        step(3);
        check_reset_vals("rst");
        check("rst8_no_signal", 64'(bus8.no_signal), 64'd1);
        rst = 1'b0;

        // steady 20-cycle period, 5 high
        rearm(0, 8);
        send_pulse(0, 5, 15);
        check("first_rise_no_signal", 64'(bus32.no_signal), 64'd0);
        check("first_rise_count", 64'(bus32.pulse_count), 64'd1);
        for (int i = 0; i < 5; i++) send_pulse(0, 5, 15);
        check("train_count", 64'(bus32.pulse_count), 64'd6);

        // train stops low: timeout at 50 cycles after the last rise
        idle(0, 32);
        @(negedge clk);
        check("ns_before_tmo", 64'(bus32.no_signal), 64'd0);
        idle(0, 1);
        @(negedge clk);
        check("ns_at_tmo", 64'(bus32.no_signal), 64'd1);
        idle(0, 10);
        check("tmo_hold_pw", 64'(bus32.pw_meas), 64'd5);
        check("tmo_hold_pri", 64'(bus32.pri_meas), 64'd20);
        for (int i = 0; i < 3; i++) send_pulse(0, 5, 15);

        // period exactly at the timeout publishes, one past it does not
        send_pulse(0, 5, 45);
        send_pulse(0, 5, 45);
        send_pulse(0, 5, 46);
        send_pulse(0, 5, 15);
        send_pulse(0, 5, 15);
        idle(0, 60);

        // random trains, timeout 30 then disabled
        set_tmo(0, 30);
        for (int i = 0; i < 30; i++)
            send_pulse(0, int'($urandom_range(1, 8)), int'($urandom_range(1, 40)));
        idle(0, 40);
        set_tmo(0, 0);
        for (int i = 0; i < 20; i++)
            send_pulse(0, int'($urandom_range(1, 10)), int'($urandom_range(1, 60)));

        // enable dropped mid-pulse and restored while still high
        send_pulse(0, 5, 15);
        send_pulse(0, 5, 15);
        set_pin(0, 1'b1);
        step(2);
        bus32.enable = 1'b0;
        step(4);
        check("dis_no_signal", 64'(bus32.no_signal), 64'd1);
        check("dis_count_held", 64'(bus32.pulse_count), 64'(cnt[0]));
        check("dis_pw_held", 64'(bus32.pw_meas), 64'(last_pw[0]));
        bus32.enable = 1'b1;
        step(3);
        check("reen_count_clr", 64'(bus32.pulse_count), 64'd0);
        check("reen_no_signal", 64'(bus32.no_signal), 64'd1);
        cnt[0] = 0;
        rearm(0, 8);
        for (int i = 0; i < 4; i++) send_pulse(0, 6, 14);

        // async reset mid-period, line high at release
        #3;
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        set_pin(0, 1'b1);
        step(2);
        rst = 1'b0;
        model_reset();
        step(6);
        rearm(0, 10);
        send_pulse(0, 5, 15);
        check("partial_ignored_count", 64'(bus32.pulse_count), 64'd1);
        send_pulse(0, 5, 15);
        send_pulse(0, 5, 15);
        idle(0, 10);

        // 8-bit instance: saturation of interval and width
        bus8.enable = 1'b1;
        rearm(1, 8);
        send_pulse(1, 10, 290);
        send_pulse(1, 10, 290);
        send_pulse(1, 10, 50);
        send_pulse(1, 300, 20);
        send_pulse(1, 5, 10);
        send_pulse(1, 5, 10);
        idle(1, 10);
        idle(0, 10);

        check("q32_drained", 64'(q32.size()), 64'd0);
        check("q8_drained", 64'(q8.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_train_analyzer.md
# pulse_train_analyzer

Receive-side companion to the waveform generator's counter: measures an incoming pulse train (typically a looped-back `counter_out`) and reports pulse width, pulse repetition interval and pulse count in `clk_in` cycles. It sits in the waveform IP's readback path. Its results are used to self-check DR/PW/PRI programming and to detect loss of signal.

## Interface
- `CNT_W`, default 32: width of all measurement counters and outputs.
- `SYNC_STAGES`, default 2: synchronizer depth on `pulse_in`; legal values are 2 or 3.
- `clk_in  input  1`: single clock; all logic runs on the rising edge.
- `reset  input  1`: asynchronous, active-high reset.
- `enable  input  1`: measurement enable.
  - When 0, the FSM is forced to ARM and the counters are cleared.
  - Published outputs are held while `enable` is 0.
- `pulse_in  input  1`: pulse train under test; treated as asynchronous.
- `timeout_cycles  input  CNT_W`: loss-of-signal limit; 0 disables the timeout.
- `pw_meas  output  CNT_W`: width of the last complete pulse, in cycles of high level.
- `pri_meas  output  CNT_W`: rising-edge-to-rising-edge interval of the last complete period.
- `meas_valid  output  1`: one-cycle strobe when `pw_meas`/`pri_meas` update.
- `meas_sat  output  1`: the published measurement saturated; updated with `meas_valid`.
- `pulse_count  output  CNT_W`: accepted rising edges since reset or since `enable` rose; wraps.
- `no_signal  output  1`: high when no valid period is in progress.

## Operation
- Synchronizer and edge detect:
  - `pulse_in` passes through `SYNC_STAGES` flops to give `pulse_s`; one further flop gives `pulse_d`.
  - rise = `pulse_s & ~pulse_d`; fall = `~pulse_s & pulse_d`.
- Internal counters `pw_cnt`, `pri_cnt` and `pw_hold` are CNT_W wide.
  - Each counter saturates at 2^CNT_W-1.
  - Each has a saturation flag that is cleared when the counter restarts.
- FSM states and transitions:
  - ARM: wait for `pulse_s`=0, then go to WAIT. This discards a partial first pulse.
  - WAIT: on rise, set `pw_cnt`=1, `pri_cnt`=1, increment `pulse_count`, clear `no_signal`, go to HIGH. Nothing is published.
  - HIGH: `pri_cnt`+1 every cycle and `pw_cnt`+1 while `pulse_s`=1. On fall: `pw_hold`<=`pw_cnt`, go to LOW.
  - LOW: `pri_cnt`+1 every cycle. On rise, do all of the following in one edge:
    - publish `pw_meas`<=`pw_hold` and `pri_meas`<=`pri_cnt`;
    - set `meas_sat` to the OR of the two saturation flags;
    - pulse `meas_valid`, increment `pulse_count`;
    - restart the counters at 1 and go to HIGH.
- Timeout: in HIGH or LOW with `timeout_cycles`≠0 and `pri_cnt` >= `timeout_cycles`:
  - set `no_signal`=1 and go to WAIT;
  - there is no publish, and `pw_meas`/`pri_meas` hold their values.
- Simultaneous events:
  - rise and timeout in the same cycle: rise wins and is processed normally.
  - `enable`=0 with any edge: `enable` wins.
- `enable` low: go to ARM, `no_signal`=1, `pulse_count` held. `pulse_count` is cleared on the first cycle `enable` is seen high again.
- A generator output high over counter values DR..DR+PW gives `pw_meas` = PW+1. A generator period PRI gives `pri_meas` = PRI+1.

## Timing
- Reset values:
  - `pw_meas`=0, `pri_meas`=0, `meas_valid`=0, `meas_sat`=0, `pulse_count`=0, `no_signal`=1.
  - FSM=ARM, all internal counters and flags 0.
- Latency: `meas_valid` is high in the cycle after the (SYNC_STAGES+1)th `clk_in` edge following the first edge that samples `pulse_in` high. With the default, that is 3 edges.
- `meas_valid` is never high for two consecutive cycles, because the minimum legal period is 2 cycles.
- A one-cycle-high pulse measures `pw_meas`=1.
- `pw_meas`, `pri_meas` and `meas_sat` change only in the same cycle `meas_valid` is high.
- Asserting `reset` mid-measurement clears everything immediately (asynchronously). No partial result is published after release.

## Test plan
- Reset release, `enable`=1, period of 20 cycles with 5 high:
  - `no_signal` falls after the first rise, with no `meas_valid`;
  - from the second rise on, `meas_valid` every 20 cycles with `pw_meas`=5, `pri_meas`=20;
  - `pulse_count` increments per rise.
- `pulse_in` already high at reset release: the first partial pulse is ignored. The first publish comes 2 full rises after `pulse_in` first goes low.
- `timeout_cycles`=50 with the train stopped low after 3 periods:
  - `no_signal`=1 exactly when `pri_cnt` reaches 50;
  - outputs hold 5/20;
  - on restart, the next publish occurs only after 2 rises.
- Rise coincident with `pri_cnt`=`timeout_cycles`: `meas_valid`=1 and `no_signal` stays 0.
- CNT_W=8 and a 300-cycle period with 10 high: `pri_meas`=255, `meas_sat`=1, `pw_meas`=10.
- `enable` dropped mid-pulse, then reasserted:
  - `pulse_count` clears on re-enable, `no_signal`=1;
  - measurements resume correctly after 2 rises;
  - async `reset` pulsed mid-period returns all outputs to their reset values.
